// File: rtl/dma_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : dma_pkg                                                        |
// | Purpose : Shared encodings for the dma_copy_engine slice: AXI response   |
// |           codes, the control FSM state encoding and the write-side       |
// |           state encoding.                                                |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package dma_pkg;

  // AXI response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Control FSM
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Write-side FSM
  localparam logic [1:0] W_IDLE      = 2'd0;
  localparam logic [1:0] W_ADDR_DATA = 2'd1;
  localparam logic [1:0] W_RESP      = 2'd2;

  // Anything other than OKAY is treated as a failed beat.
  function automatic logic resp_is_error(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage : dma_pkg
`default_nettype wire

// File: rtl/dma_sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : dma_sync_fifo                                                  |
// | Purpose : Single-clock FIFO with registered read data. A pop at edge K   |
// |           presents the word on rd_data from K onwards and holds it until |
// |           the next pop.                                                  |
// | Ports   : clk, reset (sync, active-high), clear (sync flush),            |
// |           wr_en/wr_data (push), rd_en/rd_data (pop), full, empty, count. |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module dma_sync_fifo #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              clear,
  input  logic                              wr_en,
  input  logic [DATA_W-1:0]                 wr_data,
  input  logic                              rd_en,
  output logic [DATA_W-1:0]                 rd_data,
  output logic                              full,
  output logic                              empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH+1);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              do_wr, do_rd;

  assign full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Depth is a power of two, so the pointers wrap naturally.
      if (do_wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_rd) begin
        rd_ptr_d  = rd_ptr_q + PTR_W'(1);
        rd_data_d = mem_q[rd_ptr_q];
      end
      count_d = count_q + CNT_W'(do_wr) - CNT_W'(do_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_wr && !clear) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = rd_data_q;
  assign count   = count_q;

endmodule : dma_sync_fifo
`default_nettype wire

// File: rtl/dma_copy_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : dma_copy_engine                                                |
// | Purpose : AXI-lite memory-to-memory copy engine. Reads `length` words    |
// |           from src_addr with several reads in flight, buffers them in a  |
// |           FIFO and writes them one beat at a time to dst_addr.           |
// | Ports   : clk, reset (sync, active-high); start/src_addr/dst_addr/length |
// |           command; busy/done/error status; AXI-lite AR, R, AW, W, B.     |
// | Macro   : DMA_RESP_CHECK_EN - when defined, non-OKAY rresp/bresp sets    |
// |           error and drains the transfer; otherwise responses ignored.    |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module dma_copy_engine
  import dma_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int LEN_W           = 16,
  parameter int FIFO_DEPTH      = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING+1);
  localparam int CNT_W = $clog2(FIFO_DEPTH+1);
  localparam int SUM_W = ((CNT_W > OUT_W) ? CNT_W : OUT_W) + 2;
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(DATA_W / 8);

  logic [1:0]        state_q, state_d;
  logic [1:0]        w_state_q, w_state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [LEN_W-1:0]  rd_left_q, rd_left_d;
  logic [LEN_W-1:0]  wr_left_q, wr_left_d;
  logic [OUT_W-1:0]  outst_q, outst_d;
  logic              arvalid_q, arvalid_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;

  logic              ar_hs, r_hs, b_hs, start_ok, r_err, b_err;
  logic              fifo_push, fifo_pop, fifo_empty, fifo_full_unused;
  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_W-1:0] fifo_rdata;

  assign busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done     = (state_q == ST_DONE);
  // Every AR reserves a FIFO slot, so R can always be accepted.
  assign rready   = busy;
  assign ar_hs    = arvalid_q && arready;
  assign r_hs     = rvalid && rready;
  assign b_hs     = bvalid && bready_q;
  assign start_ok = start && (state_q == ST_IDLE);
  // Failing R data is dropped; DRAIN discards everything.
  assign fifo_push = r_hs && (state_q == ST_RUN) && !r_err;

`ifdef DMA_RESP_CHECK_EN
  logic error_q, error_d;

  assign r_err = r_hs && resp_is_error(rresp);
  assign b_err = b_hs && resp_is_error(bresp);

  always_comb begin
    error_d = error_q;
    if (start_ok)            error_d = 1'b0;
    else if (r_err || b_err) error_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) error_q <= 1'b0;
    else       error_q <= error_d;
  end

  assign error = error_q;
`else
  logic resp_unused;
  assign resp_unused = ^{rresp, bresp};
  assign r_err = 1'b0;
  assign b_err = 1'b0;
  assign error = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    w_state_d = w_state_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    rd_left_d = rd_left_q;
    wr_left_d = wr_left_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    fifo_pop  = 1'b0;

    // ---------------- read side ----------------
    if (ar_hs) begin
      rd_addr_d = rd_addr_q + STRIDE;
      rd_left_d = rd_left_q - LEN_W'(1);
    end
    outst_d = outst_q + OUT_W'(ar_hs) - OUT_W'(r_hs);

    if (state_q == ST_IDLE) begin
      arvalid_d = 1'b0;
    end else if (arvalid_q && !arready) begin
      arvalid_d = 1'b1;
    end else begin
      // The FIFO term counts beats accepted this cycle (still in outst_q)
      // and ignores a concurrent pop, so the slot budget is conservative.
      arvalid_d = (state_q == ST_RUN) && !r_err && !b_err &&
                  (rd_left_d != '0) &&
                  (outst_d < OUT_W'(MAX_OUTSTANDING)) &&
                  ((SUM_W'(outst_q) + SUM_W'(ar_hs) + SUM_W'(fifo_count))
                     < SUM_W'(FIFO_DEPTH));
    end

    // ---------------- control FSM ----------------
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (length == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d   = ST_RUN;
            rd_addr_d = src_addr;
            wr_addr_d = dst_addr;
            rd_left_d = length;
            wr_left_d = length;
            arvalid_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (r_err || b_err)                          state_d = ST_DRAIN;
        else if (b_hs && (wr_left_q == LEN_W'(1)))   state_d = ST_DONE;
      end
      ST_DRAIN: begin
        if ((outst_q == '0) && !arvalid_q && (w_state_q == W_IDLE))
          state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    // ---------------- write side ----------------
    case (w_state_q)
      W_IDLE: begin
        if ((state_q == ST_RUN) && !fifo_empty && !r_err && !b_err) begin
          fifo_pop  = 1'b1;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          w_state_d = W_ADDR_DATA;
        end
      end
      W_ADDR_DATA: begin
        awvalid_d = awvalid_q && !awready;
        wvalid_d  = wvalid_q && !wready;
        if (!awvalid_d && !wvalid_d) begin
          w_state_d = W_RESP;
          bready_d  = 1'b1;
        end
      end
      W_RESP: begin
        if (b_hs) begin
          bready_d  = 1'b0;
          w_state_d = W_IDLE;
          wr_addr_d = wr_addr_q + STRIDE;
          wr_left_d = wr_left_q - LEN_W'(1);
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      w_state_q <= W_IDLE;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      rd_left_q <= '0;
      wr_left_q <= '0;
      outst_q   <= '0;
      arvalid_q <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      w_state_q <= w_state_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      rd_left_q <= rd_left_d;
      wr_left_q <= wr_left_d;
      outst_q   <= outst_d;
      arvalid_q <= arvalid_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
    end
  end

  dma_sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear   (start_ok),
    .wr_en   (fifo_push),
    .wr_data (rdata),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rdata),
    .full    (fifo_full_unused),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign araddr  = rd_addr_q;
  assign arvalid = arvalid_q;
  assign awaddr  = wr_addr_q;
  assign awvalid = awvalid_q;
  // FIFO output only changes on a pop, which happens while both valids are low.
  assign wdata   = fifo_rdata;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;

endmodule : dma_copy_engine
`default_nettype wire

// File: tb/tb_dma_copy_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_dma_copy_engine                                             |
// | Purpose : Self-checking bench for dma_copy_engine with an AXI-lite slave |
// |           model (configurable R latency, random back-pressure, rresp     |
// |           injection) and an in-order write scoreboard.                   |
// | Macro   : DMA_RESP_CHECK_EN selects the expected error-path behaviour.   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_dma_copy_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0, dst_addr = '0;
  logic [15:0] length = '0;
  logic        busy, done, error;
  logic [31:0] araddr, awaddr, wdata;
  logic        arvalid, rready, awvalid, wvalid, bready;
  logic        arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0, bresp = '0;

  always #5 clk = ~clk;

  dma_copy_engine dut (
    .clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .length(length), .busy(busy), .done(done), .error(error),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- slave memory and model configuration ----------------
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  typedef struct { logic [31:0] addr; int t; } rreq_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } exp_t;

  rreq_t       rq [$];
  exp_t        exp_q [$];
  int          lat = 1;
  bit          bp = 1'b0;
  bit          inj = 1'b0;
  logic [31:0] err_addr = '1, bad_addr = '1;
  bit          err_seen = 1'b0;
  int          ar_after_err = 0, bad_writes = 0, wr_cnt = 0;
  int          done_cnt = 0, arv_cycles = 0, awv_cycles = 0;

  int          cyc = 0, out_cnt = 0;
  bit          hold_ar, hold_aw, hold_w, aw_got, w_got, r_free;
  logic [31:0] held_ar, held_aw, held_w, cap_aw, cap_w;
  rreq_t       h_req;
  exp_t        e_cur;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      rq.delete();
      out_cnt = 0; aw_got = 0; w_got = 0; hold_ar = 0; hold_aw = 0; hold_w = 0;
      arready <= 1'b0; rvalid <= 1'b0; rdata <= '0; rresp <= '0;
      awready <= 1'b0; wready <= 1'b0; bvalid <= 1'b0; bresp <= '0;
    end else begin
      if (done)    done_cnt++;
      if (arvalid) arv_cycles++;
      if (awvalid) awv_cycles++;
      if (hold_ar) check("ar_hold", 64'({arvalid, araddr}), 64'({1'b1, held_ar}));
      if (hold_aw) check("aw_hold", 64'({awvalid, awaddr}), 64'({1'b1, held_aw}));
      if (hold_w)  check("w_hold",  64'({wvalid, wdata}),   64'({1'b1, held_w}));

      // AR accepted before R error bookkeeping so a same-edge AR counts as earlier
      if (arvalid && arready) begin
        if (err_seen) ar_after_err++;
        rq.push_back('{araddr, cyc + lat});
        out_cnt++;
        check("outstanding_le_max", 64'(out_cnt <= 4), 64'(1));
      end
      hold_ar = arvalid && !arready;
      held_ar = araddr;

      r_free = !rvalid || rready;
      if (rvalid && rready) begin
        out_cnt--;
        if (rresp != 2'b00) err_seen = 1'b1;
      end
      if (r_free) begin
        if (rq.size() != 0 && rq[0].t <= cyc) begin
          h_req = rq.pop_front();
          rvalid <= 1'b1;
          rdata  <= mem_rd(h_req.addr);
          rresp  <= (inj && h_req.addr == err_addr) ? 2'b10 : 2'b00;
        end else begin
          rvalid <= 1'b0;
        end
      end

      if (bvalid && bready) bvalid <= 1'b0;
      if (awvalid && awready && !aw_got) begin aw_got = 1; cap_aw = awaddr; end
      if (wvalid && wready && !w_got)    begin w_got = 1;  cap_w = wdata;   end
      hold_aw = awvalid && !awready; held_aw = awaddr;
      hold_w  = wvalid && !wready;   held_w  = wdata;
      if (aw_got && w_got) begin
        aw_got = 0; w_got = 0;
        mem[cap_aw] = cap_w;
        wr_cnt++;
        if (cap_aw == bad_addr) bad_writes++;
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL wr_unexpected: observed write to 0x%0h expected no write", cap_aw);
        end
        if (exp_q.size() != 0) begin
          e_cur = exp_q.pop_front();
          check("wr_addr", 64'(cap_aw), 64'(e_cur.addr));
          check("wr_data", 64'(cap_w),  64'(e_cur.data));
        end
        bvalid <= 1'b1;
        bresp  <= 2'b00;
      end

      arready <= bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      awready <= bp ? ($urandom_range(0, 3) == 0) : 1'b1;
      wready  <= bp ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic fill_src(input logic [31:0] src, input int len);
    for (int i = 0; i < len; i++) mem[src + 32'(4 * i)] = $urandom;
  endtask

  task automatic start_copy(input logic [31:0] src, input logic [31:0] dst,
                            input int len, input int skip);
    for (int i = 0; i < len; i++)
      if (i != skip) exp_q.push_back('{dst + 32'(4 * i), mem_rd(src + 32'(4 * i))});
    @(negedge clk);
    start = 1'b1; src_addr = src; dst_addr = dst; length = 16'(len);
    @(negedge clk);
    start = 1'b0;
    check("arvalid_after_start", 64'(arvalid), 64'(1));
    check("busy_after_start", 64'(busy), 64'(1));
  endtask

  task automatic finish_copy();
    int n = 0;
    int d0 = done_cnt;
    while (done !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    check("done_seen", 64'(done), 64'(1));
    check("busy_low_at_done", 64'(busy), 64'(0));
    repeat (4) @(negedge clk);
    check("done_pulses", 64'(done_cnt - d0), 64'(1));
  endtask

  // ---------------- directed sequence ----------------
  logic [31:0] base_words [4];
  int          arv0, awv0, wr0;

  initial begin
    base_words[0] = 32'hAABBCCDD; base_words[1] = 32'h11223344;
    base_words[2] = 32'h55667788; base_words[3] = 32'h99AABBCC;

    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_error", 64'(error), 64'(0));
    check("rst_valids", 64'({arvalid, awvalid, wvalid}), 64'(0));
    check("rst_readies", 64'({rready, bready}), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    // Base copy
    for (int i = 0; i < 4; i++) mem[32'h1000 + 32'(4 * i)] = base_words[i];
    start_copy(32'h1000, 32'h2000, 4, -1);
    finish_copy();
    check("base_error", 64'(error), 64'(0));
    check("base_sb_empty", 64'(exp_q.size()), 64'(0));
    for (int i = 0; i < 4; i++)
      check("base_mem", 64'(mem_rd(32'h2000 + 32'(4 * i))), 64'(base_words[i]));

    // Deep transfer with slow R, plus a start while busy that must be ignored
    lat = 5;
    fill_src(32'h3000, 20);
    start_copy(32'h3000, 32'h4000, 20, -1);
    repeat (3) @(negedge clk);
    start = 1'b1; src_addr = 32'hF000; dst_addr = 32'hF800; length = 16'd1;
    @(negedge clk);
    start = 1'b0;
    finish_copy();
    check("deep_sb_empty", 64'(exp_q.size()), 64'(0));
    lat = 1;

    // Back-pressure on AR/AW/W
    bp = 1'b1;
    fill_src(32'h5000, 12);
    start_copy(32'h5000, 32'h6000, 12, -1);
    finish_copy();
    bp = 1'b0;
    check("bp_sb_empty", 64'(exp_q.size()), 64'(0));
    check("bp_error", 64'(error), 64'(0));

    // Zero length
    arv0 = arv_cycles; awv0 = awv_cycles;
    @(negedge clk);
    start = 1'b1; length = 16'd0; src_addr = 32'h1000; dst_addr = 32'h2000;
    @(negedge clk);
    start = 1'b0;
    check("zero_done", 64'(done), 64'(1));
    check("zero_busy", 64'(busy), 64'(0));
    @(negedge clk);
    check("zero_done_drop", 64'(done), 64'(0));
    repeat (3) @(negedge clk);
    check("zero_no_ar", 64'(arv_cycles - arv0), 64'(0));
    check("zero_no_aw", 64'(awv_cycles - awv0), 64'(0));

    // SLVERR on R for word 2 of 6
    fill_src(32'h7000, 6);
    inj = 1'b1; err_addr = 32'h7008; bad_addr = 32'h8008;
    err_seen = 1'b0; ar_after_err = 0; bad_writes = 0; wr0 = wr_cnt;
`ifdef DMA_RESP_CHECK_EN
    start_copy(32'h7000, 32'h8000, 6, 2);
    finish_copy();
    check("err_flag", 64'(error), 64'(1));
    check("err_seen_by_slave", 64'(err_seen), 64'(1));
    check("err_no_ar_after", 64'(ar_after_err), 64'(0));
    check("err_word2_unwritten", 64'(bad_writes), 64'(0));
    exp_q.delete();
`else
    start_copy(32'h7000, 32'h8000, 6, -1);
    finish_copy();
    check("err_ignored_flag", 64'(error), 64'(0));
    check("err_ignored_word2", 64'(bad_writes), 64'(1));
    check("err_ignored_count", 64'(wr_cnt - wr0), 64'(6));
    check("err_ignored_sb_empty", 64'(exp_q.size()), 64'(0));
`endif
    inj = 1'b0;

    // Mid-transfer reset of a 16-beat copy, then a fresh copy
    fill_src(32'h9000, 16);
    start_copy(32'h9000, 32'hB000, 16, -1);
    check("error_cleared_on_start", 64'(error), 64'(0));
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mrst_valids", 64'({arvalid, awvalid, wvalid}), 64'(0));
    check("mrst_busy_done", 64'({busy, done}), 64'(0));
    check("mrst_readies", 64'({rready, bready}), 64'(0));
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    start_copy(32'h1000, 32'hA000, 4, -1);
    finish_copy();
    check("post_rst_sb_empty", 64'(exp_q.size()), 64'(0));
    for (int i = 0; i < 4; i++)
      check("post_rst_mem", 64'(mem_rd(32'hA000 + 32'(4 * i))), 64'(base_words[i]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_dma_copy_engine
`default_nettype wire
